// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: DIFF = A - B - BIN computed 4 bits per clock
// through a single ripple slice, with valid/ready handshakes on both sides.

module nibble_sub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] brw;

  always_comb begin
    brw    = '0;
    diff   = '0;
    brw[0] = bin;
    for (int i = 0; i < 4; i++) begin
      diff[i]  = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
  end

  assign bout = brw[4];

endmodule

module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             brw;
  logic [CW+1:0]    base;
  logic [3:0]       s_diff;
  logic             s_bout;
  logic [WIDTH-1:0] diff_next;
  logic             ovf_next;

  assign base = {cnt, 2'b00};

  nibble_sub_slice u_slice (
    .a    (a_reg[base +: 4]),
    .b    (b_reg[base +: 4]),
    .bin  (brw),
    .diff (s_diff),
    .bout (s_bout)
  );

  // Full-width view of the result including the nibble being produced now,
  // so the flags can be registered on the final RUN cycle.
  always_comb begin
    diff_next             = diff;
    diff_next[base +: 4]  = s_diff;
    ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
               (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      brw       <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            brw      <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff <= diff_next;
          brw  <= s_bout;
          if (cnt == LAST) begin
            bout      <= s_bout;
            ovf       <= ovf_next;
            zero      <= (diff_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub: driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.

module tb_nibble_serial_sub;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  logic        rand_ready = 1'b0;
  logic        rnd_bit = 1'b1;
  logic        force_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_sent   = 0;
  int n_recv   = 0;
  exp_t sb[$];
  exp_t mon_e;

  assign out_ready = rand_ready ? rnd_bit : force_ready;

  nibble_serial_sub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  function automatic exp_t mk(input logic [15:0] d, input logic bo,
                              input logic ov, input logic z);
    exp_t e;
    e.diff = d; e.bout = bo; e.ovf = ov; e.zero = z;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mbin);
    logic [16:0] full;
    exp_t e;
    full   = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    e.diff = full[15:0];
    e.bout = full[16];
    e.ovf  = (ma[15] != mb[15]) && (full[15] != ma[15]);
    e.zero = (full[15:0] == 16'd0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               input logic tbin, input exp_t e, input bit push);
    int waited;
    waited   = 0;
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("[TB] FAIL accept_timeout actual=in_ready=0 required=1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      sb.push_back(e);
      n_sent++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_recv++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_result actual=%h required=none", diff);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("diff", diff, mon_e.diff);
        checkOutput("bout", bout, mon_e.bout);
        checkOutput("ovf", ovf, mon_e.ovf);
        checkOutput("zero", zero, mon_e.zero);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] dir_a   [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555};
  logic [15:0] dir_b   [4] = '{16'h0111, 16'h0001, 16'h0001, 16'h5554};
  logic        dir_bin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  exp_t        dir_e   [4];

  initial begin
    int lat;
    int waited;
    logic [15:0] ra, rb;
    logic rbin;

    dir_e[0] = mk(16'h1123, 1'b0, 1'b0, 1'b0);
    dir_e[1] = mk(16'hFFFF, 1'b1, 1'b0, 1'b0);
    dir_e[2] = mk(16'h7FFF, 1'b0, 1'b1, 1'b0);
    dir_e[3] = mk(16'h0000, 1'b0, 1'b0, 1'b1);

    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_diff", diff, 0);
    checkOutput("rst_flags", {bout, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(dir_a[i], dir_b[i], dir_bin[i], dir_e[i], 1'b1);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 20);
      checkOutput("latency", lat, 5);
      drain();
    end

    $display("[TB] backpressure");
    force_ready = 1'b0;
    applyStimulus(16'h00FF, 16'h0F0F, 1'b0, mk(16'hF1F0, 1'b1, 1'b0, 1'b0), 1'b1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("stall_out_valid_rise", out_valid, 1);
    a = 16'hAAAA;
    b = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_diff", diff, 16'hF1F0);
      checkOutput("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    force_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("release_out_valid", out_valid, 0);
    drain();

    $display("[TB] reset mid-operation");
    applyStimulus(16'h1234, 16'h0001, 1'b0, mk(16'h1233, 1'b0, 1'b0, 1'b0), 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_diff", diff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h4321, 16'h1234, 1'b1, mk(16'h30EC, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();

    $display("[TB] random stream");
    rand_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rbin, model(ra, rb, rbin), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    force_ready = 1'b1;
    drain();
    repeat (10) @(posedge clk);
    checkOutput("result_count", n_recv, n_sent);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
